vector_regfile_stream: RTL and testbench
========================================

VECTOR_REGFILE_STREAM -- requirements
Module: vector_regfile_stream

Interface
REQ-001 SHALL have parameter NREGS, default 16, number of vector registers.
REQ-002 SHALL have parameter NLANES, default 5, elements per vector.
REQ-003 SHALL have parameter XLEN, default 32, element width in bits.
REQ-004 SHALL have parameter AW, default 4, register-index width; NREGS <= 2**AW.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-007 SHALL have ports ra1, ra2  input  AW  read-port register indices.
REQ-008 SHALL have ports rd1, rd2  output  NLANES*XLEN  read data; lane i at bits [i*XLEN +: XLEN].
REQ-009 SHALL have ports we  input  1, wa  input  AW, wmask  input  NLANES, wd  input  NLANES*XLEN: full-vector write port with per-lane mask.
REQ-010 SHALL have ports ld_start  input  1, ld_vd  input  AW: start an element-serial load into ld_vd.
REQ-011 SHALL have ports ld_valid  input  1, ld_data  input  XLEN, ld_ready  output  1: element stream handshake.
REQ-012 SHALL have ports ld_done  output  1 (one-cycle completion pulse) and busy  output  NREGS (per-register load-in-progress flags).

Function
REQ-013 Read ports SHALL be combinational: rdN = stored contents of register raN; raN >= NREGS SHALL return all zeros.
REQ-014 On a rising edge with we=1 and wa < NREGS, lane i of register wa SHALL take wd lane i for every i with wmask[i]=1; unmasked lanes SHALL be unchanged; wa >= NREGS SHALL be ignored.
REQ-015 Load FSM states SHALL be IDLE, FILL, DONE.
REQ-016 IDLE: ld_ready=0; ld_start=1 with ld_vd < NREGS SHALL latch ld_vd, clear lane counter to 0, set busy[ld_vd], go to FILL; ld_start with ld_vd >= NREGS SHALL be ignored.
REQ-017 FILL: ld_ready=1; each cycle with ld_valid=1 SHALL write ld_data to lane counter of the latched register and increment the counter; a transfer at counter NLANES-1 SHALL move to DONE.
REQ-018 FILL with ld_valid=0 SHALL hold state and counter indefinitely.
REQ-019 DONE: ld_ready=0, ld_done=1 for exactly one cycle, busy bit cleared on exit, return to IDLE.
REQ-020 ld_start outside IDLE SHALL be ignored (no restart, no error).
REQ-021 Simultaneous write-port write and stream transfer to the same register and lane SHALL store the stream value; other masked lanes SHALL take wd.
REQ-022 Write-port writes to a busy register SHALL be permitted per REQ-014/REQ-021.
REQ-023 Element-load latency: a stream element SHALL be visible on a read port the cycle after its transfer; ld_done SHALL assert the cycle after the final transfer.

Reset
REQ-024 reset=0 SHALL immediately clear all NREGS*NLANES elements, lane counter, latched index and busy to zero and force FSM to IDLE, including mid-FILL (partial load discarded, no ld_done).
REQ-025 During and after reset, until first event: ld_ready=0, ld_done=0, busy=0, rd1=rd2=0.

Configuration
REQ-026 Macro VRF_BYPASS_EN defined: each read lane SHALL return the value being written into that register and lane this cycle (stream value over wd per REQ-021), else stored value.
REQ-027 VRF_BYPASS_EN undefined: reads SHALL return stored values only; writes become visible the following cycle.

Verification
REQ-028 Reset then we=1, wa=3, wmask=5'b10101, wd lanes=1..5 -> next cycle ra1=3 reads lanes {1,0,3,0,5}.
REQ-029 ld_start, ld_vd=7, five ld_valid beats 0xA0..0xA4 with a 2-cycle ld_valid gap after beat 2 -> busy[7]=1 throughout, ld_ready=1 only in FILL, ld_done one cycle after beat 0xA4, reg 7 = {A0..A4}, busy[7]=0 after.
REQ-030 Same cycle: stream beat lane 0 = 0x55 to reg 2 and we to wa=2, wmask=all, wd lanes=0x11 -> reg 2 lane0=0x55, lanes1-4=0x11.
REQ-031 Reset pulled low after 3 beats of a load into reg 4 -> all registers 0, FSM IDLE, no ld_done, busy=0; new ld_start accepted after release.
REQ-032 With VRF_BYPASS_EN, we to wa=1 wd lane0=0xDEAD and ra1=1 -> rd1 lane0=0xDEAD same cycle; without macro -> old value same cycle, 0xDEAD next cycle.

Source files
------------

// File: rtl/vector_regfile_stream_if.sv
// -----------------------------------------------------------------------------
// vector_regfile_stream_if
//
// Purpose : element-serial load channel of the vector register file. A
//           producer (master) starts a load into one vector register and then
//           streams that register's elements one per accepted beat.
//
// Parameters:
//   XLEN - element width in bits
//   AW   - register-index width
//
// Signals:
//   ld_start  master->slave  request a load into register ld_vd
//   ld_vd     master->slave  destination register index
//   ld_valid  master->slave  ld_data carries an element this cycle
//   ld_data   master->slave  element value
//   ld_ready  slave->master  register file is accepting elements
//   ld_done   slave->master  one-cycle pulse, the last element was stored
// -----------------------------------------------------------------------------
interface vector_regfile_stream_if #(
  parameter int XLEN = 32,
  parameter int AW   = 4
);
  logic            ld_start;
  logic [AW-1:0]   ld_vd;
  logic            ld_valid;
  logic [XLEN-1:0] ld_data;
  logic            ld_ready;
  logic            ld_done;

  modport master (
    output ld_start, ld_vd, ld_valid, ld_data,
    input  ld_ready, ld_done
  );

  modport slave (
    input  ld_start, ld_vd, ld_valid, ld_data,
    output ld_ready, ld_done
  );
endinterface

// File: rtl/vector_regfile_stream.sv
// -----------------------------------------------------------------------------
// vector_regfile_stream
//
// Purpose : NREGS x NLANES x XLEN vector register file with two combinational
//           read ports, one full-vector write port with a per-lane mask and an
//           element-serial load engine fed through vector_regfile_stream_if.
//
// Optional feature (macro VRF_BYPASS_EN):
//   defined   - read lanes forward the value being written this cycle
//               (stream element has priority over the write port)
//   undefined - reads return stored contents only; writes appear next cycle
//
// Ports:
//   clk        single clock, all state changes on the rising edge
//   reset      asynchronous, active-low reset
//   ra1, ra2   read register indices (index >= NREGS reads as zero)
//   rd1, rd2   read data, lane i at [i*XLEN +: XLEN]
//   we         write-port enable
//   wa         write register index (index >= NREGS is ignored)
//   wmask      per-lane write mask
//   wd         write data, lane i at [i*XLEN +: XLEN]
//   ld_if      load stream channel (slave side)
//   busy       per-register load-in-progress flags
// -----------------------------------------------------------------------------
module vector_regfile_stream #(
  parameter int NREGS  = 16,
  parameter int NLANES = 5,
  parameter int XLEN   = 32,
  parameter int AW     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [AW-1:0]            ra1,
  input  logic [AW-1:0]            ra2,
  output logic [NLANES*XLEN-1:0]   rd1,
  output logic [NLANES*XLEN-1:0]   rd2,
  input  logic                     we,
  input  logic [AW-1:0]            wa,
  input  logic [NLANES-1:0]        wmask,
  input  logic [NLANES*XLEN-1:0]   wd,
  vector_regfile_stream_if.slave   ld_if,
  output logic [NREGS-1:0]         busy
);

  localparam int              CW        = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam logic [CW-1:0]   LAST_LANE = CW'(NLANES - 1);
  localparam logic [AW:0]     NREGS_W   = (AW + 1)'(NREGS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DONE
  } ld_state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] r_mem [NREGS][NLANES];

  ld_state_e       r_state;
  logic [CW-1:0]   r_cnt;       // next lane to be filled by the stream
  logic [AW-1:0]   r_vd;        // register being loaded
  logic            r_ld_ready;
  logic            r_ld_done;
  logic [NREGS-1:0] r_busy;

  logic            w_xfer;      // stream element accepted this cycle
  logic            w_start_ok;  // ld_vd names an existing register

  assign w_xfer     = (r_state == S_FILL) && ld_if.ld_valid;
  assign w_start_ok = ({1'b0, ld_if.ld_vd} < NREGS_W);

  assign ld_if.ld_ready = r_ld_ready;
  assign ld_if.ld_done  = r_ld_done;
  assign busy           = r_busy;

  // ---------------------------------------------------------------------------
  // Storage array
  //
  // An index >= NREGS never equals any loop index r, so out-of-range writes
  // fall through without a separate range check.
  // ---------------------------------------------------------------------------
  // NOTE: the whole array is reset because a reset must discard every element,
  // including a half-finished load; this forces flops rather than an SRAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) begin
        for (int l = 0; l < NLANES; l++) begin
          r_mem[r][l] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        for (int l = 0; l < NLANES; l++) begin
          if (we && (wa == AW'(r)) && wmask[l]) begin
            r_mem[r][l] <= wd[l*XLEN +: XLEN];
          end
          // NOTE: non-blocking assignments resolve last-writer-wins, so the
          // stream assignment placed after the write-port one takes priority
          // when both target the same register and lane.
          if (w_xfer && (r_vd == AW'(r)) && (r_cnt == CW'(l))) begin
            r_mem[r][l] <= ld_if.ld_data;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load FSM with registered ld_ready / ld_done / busy
  //
  // ld_ready is high exactly while in FILL, so it is set on entry and cleared
  // on the final transfer. busy stays set through the DONE cycle and drops
  // when returning to IDLE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_vd       <= '0;
      r_ld_ready <= 1'b0;
      r_ld_done  <= 1'b0;
      r_busy     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ld_if.ld_start && w_start_ok) begin
            r_vd              <= ld_if.ld_vd;
            r_cnt             <= '0;
            r_busy[ld_if.ld_vd] <= 1'b1;
            r_ld_ready        <= 1'b1;
            r_state           <= S_FILL;
          end
        end
        S_FILL: begin
          // ld_start is deliberately not looked at here: a running load is
          // never restarted.
          if (ld_if.ld_valid) begin
            if (r_cnt == LAST_LANE) begin
              r_ld_ready <= 1'b0;
              r_ld_done  <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_ld_done    <= 1'b0;
          r_busy[r_vd] <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_ld_ready <= 1'b0;
          r_ld_done  <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  logic [AW-1:0]          w_ra [2];
  logic [NLANES*XLEN-1:0] w_rd [2];

  assign w_ra[0] = ra1;
  assign w_ra[1] = ra2;
  assign rd1     = w_rd[0];
  assign rd2     = w_rd[1];

`ifdef VRF_BYPASS_EN
  // The write port is gated by reset so reads stay zero while reset is held
  // even if the write inputs are active.
  logic w_byp_we;
  assign w_byp_we = we && reset;
`endif

  // NOTE: every output of this block gets a default before the loops, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rd[p] = '0;
      for (int r = 0; r < NREGS; r++) begin
        if (w_ra[p] == AW'(r)) begin
          for (int l = 0; l < NLANES; l++) begin
`ifdef VRF_BYPASS_EN
            if (w_xfer && (r_vd == AW'(r)) && (r_cnt == CW'(l))) begin
              w_rd[p][l*XLEN +: XLEN] = ld_if.ld_data;
            end else if (w_byp_we && (wa == AW'(r)) && wmask[l]) begin
              w_rd[p][l*XLEN +: XLEN] = wd[l*XLEN +: XLEN];
            end else begin
              w_rd[p][l*XLEN +: XLEN] = r_mem[r][l];
            end
`else
            w_rd[p][l*XLEN +: XLEN] = r_mem[r][l];
`endif
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_regfile_stream.sv
// -----------------------------------------------------------------------------
// tb_vector_regfile_stream
//
// Self-checking bench for vector_regfile_stream. The register file is modelled
// as a plain 2-D array updated with the write/load rules; the stream model
// simply stores the k-th accepted element of a load in lane k. NREGS is set
// below 2**AW so out-of-range indices can be exercised.
// -----------------------------------------------------------------------------
module tb_vector_regfile_stream;

  localparam int NREGS  = 12;
  localparam int NLANES = 5;
  localparam int XLEN   = 32;
  localparam int AW     = 4;
  localparam int VW     = NLANES * XLEN;

  logic              clk   = 1'b0;
  logic              reset = 1'b1;
  logic [AW-1:0]     ra1, ra2, wa;
  logic [VW-1:0]     rd1, rd2, wd;
  logic              we;
  logic [NLANES-1:0] wmask;
  logic [NREGS-1:0]  busy;

  vector_regfile_stream_if #(.XLEN(XLEN), .AW(AW)) ld_if ();

  vector_regfile_stream #(
    .NREGS (NREGS),
    .NLANES(NLANES),
    .XLEN  (XLEN),
    .AW    (AW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .ra1  (ra1),
    .ra2  (ra2),
    .rd1  (rd1),
    .rd2  (rd2),
    .we   (we),
    .wa   (wa),
    .wmask(wmask),
    .wd   (wd),
    .ld_if(ld_if),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Reference model
  logic [XLEN-1:0] m [NREGS][NLANES];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [VW-1:0] mvec(input int r);
    logic [VW-1:0] v;
    v = '0;
    if (r < NREGS) begin
      for (int l = 0; l < NLANES; l++) v[l*XLEN +: XLEN] = m[r][l];
    end
    return v;
  endfunction

  task automatic model_write(input int a, input logic [NLANES-1:0] mk, input logic [VW-1:0] d);
    if (a < NREGS) begin
      for (int l = 0; l < NLANES; l++) if (mk[l]) m[a][l] = d[l*XLEN +: XLEN];
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < NREGS; r++) for (int l = 0; l < NLANES; l++) m[r][l] = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    we = 0; wa = 0; wmask = 0; wd = '0; ra1 = 0; ra2 = 5;
    ld_if.ld_start = 0; ld_if.ld_vd = 0; ld_if.ld_valid = 0; ld_if.ld_data = '0;
    #2 reset = 1'b0;
    #1;
    model_clear();
    n_checks++; if (ld_if.ld_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ld_if.ld_ready); end
    n_checks++; if (ld_if.ld_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", ld_if.ld_done); end
    n_checks++; if (busy !== '0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", busy); end
    n_checks++; if (rd1 !== '0 || rd2 !== '0) begin n_fail++; $display("FAIL reset_rd: got %h / %h want 0", rd1, rd2); end
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    tick();
    n_checks++; if (ld_if.ld_ready !== 1'b0 || ld_if.ld_done !== 1'b0 || busy !== '0) begin
      n_fail++; $display("FAIL post_reset_ctrl: ready=%b done=%b busy=%h want 0/0/0", ld_if.ld_ready, ld_if.ld_done, busy);
    end
    n_checks++; if (rd1 !== '0 || rd2 !== '0) begin n_fail++; $display("FAIL post_reset_rd: got %h / %h want 0", rd1, rd2); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_masked_write();
    logic [VW-1:0] exp28;
    exp28 = {32'd5, 32'd0, 32'd3, 32'd0, 32'd1};
    we = 1; wa = 3; wmask = 5'b10101;
    for (int l = 0; l < NLANES; l++) wd[l*XLEN +: XLEN] = 32'(l + 1);
    tick();
    model_write(3, wmask, wd);
    we = 0; ra1 = 3;
    #1;
    n_checks++; if (rd1 !== exp28) begin n_fail++; $display("FAIL masked_write: got %h want %h", rd1, exp28); end

    // Random masked writes, including indices beyond NREGS
    for (int i = 0; i < 60; i++) begin
      we    = 1'($urandom_range(0, 1));
      wa    = AW'($urandom_range(0, 15));
      wmask = NLANES'($urandom);
      for (int l = 0; l < NLANES; l++) wd[l*XLEN +: XLEN] = $urandom;
      ra1   = AW'($urandom_range(0, 15));
      ra2   = wa;
      tick();
      if (we) model_write(int'(wa), wmask, wd);
      we = 0;
      #1;
      n_checks++; if (rd1 !== mvec(int'(ra1))) begin n_fail++; $display("FAIL rand_rd1 ra=%0d: got %h want %h", ra1, rd1, mvec(int'(ra1))); end
      n_checks++; if (rd2 !== mvec(int'(ra2))) begin n_fail++; $display("FAIL rand_rd2 ra=%0d: got %h want %h", ra2, rd2, mvec(int'(ra2))); end
    end

    // Load requests to nonexistent registers are ignored
    for (int v = NREGS; v < 16; v += 3) begin
      ld_if.ld_start = 1; ld_if.ld_vd = AW'(v);
      tick();
      ld_if.ld_start = 0;
      tick();
      n_checks++; if (ld_if.ld_ready !== 1'b0 || busy !== '0) begin
        n_fail++; $display("FAIL oob_start vd=%0d: ready=%b busy=%h want 0/0", v, ld_if.ld_ready, busy);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_stream_load();
    logic [VW-1:0]    exp29;
    logic [NREGS-1:0] b7;
    b7 = NREGS'(1) << 7;
    exp29 = {32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0};
    ra1 = 7; ra2 = 0;
    #1;
    n_checks++; if (ld_if.ld_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready: got %b want 0", ld_if.ld_ready); end
    ld_if.ld_start = 1; ld_if.ld_vd = 7;
    tick();
    ld_if.ld_start = 0;
    n_checks++; if (busy !== b7) begin n_fail++; $display("FAIL load_busy_start: got %h want %h", busy, b7); end
    n_checks++; if (ld_if.ld_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready: got %b want 1", ld_if.ld_ready); end
    for (int k = 0; k < NLANES; k++) begin
      if (k == 3) begin
        // Two idle cycles; a second ld_start here must not disturb the load
        repeat (2) begin
          ld_if.ld_valid = 0; ld_if.ld_start = 1; ld_if.ld_vd = 2;
          tick();
          ld_if.ld_start = 0;
          n_checks++; if (ld_if.ld_ready !== 1'b1 || busy !== b7 || ld_if.ld_done !== 1'b0) begin
            n_fail++; $display("FAIL gap_hold: ready=%b busy=%h done=%b want 1/%h/0", ld_if.ld_ready, busy, ld_if.ld_done, b7);
          end
        end
      end
      ld_if.ld_valid = 1; ld_if.ld_data = 32'hA0 + 32'(k);
      tick();
      ld_if.ld_valid = 0;
      m[7][k] = 32'hA0 + 32'(k);
      n_checks++; if (rd1 !== mvec(7)) begin n_fail++; $display("FAIL beat_visible k=%0d: got %h want %h", k, rd1, mvec(7)); end
      n_checks++; if (busy !== b7) begin n_fail++; $display("FAIL beat_busy k=%0d: got %h want %h", k, busy, b7); end
      if (k < NLANES - 1) begin
        n_checks++; if (ld_if.ld_done !== 1'b0 || ld_if.ld_ready !== 1'b1) begin
          n_fail++; $display("FAIL beat_ctrl k=%0d: done=%b ready=%b want 0/1", k, ld_if.ld_done, ld_if.ld_ready);
        end
      end
    end
    n_checks++; if (ld_if.ld_done !== 1'b1) begin n_fail++; $display("FAIL load_done: got %b want 1", ld_if.ld_done); end
    n_checks++; if (ld_if.ld_ready !== 1'b0) begin n_fail++; $display("FAIL done_ready: got %b want 0", ld_if.ld_ready); end
    n_checks++; if (rd1 !== exp29) begin n_fail++; $display("FAIL load_contents: got %h want %h", rd1, exp29); end
    tick();
    n_checks++; if (ld_if.ld_done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_len: got %b want 0", ld_if.ld_done); end
    n_checks++; if (busy !== '0 || ld_if.ld_ready !== 1'b0) begin
      n_fail++; $display("FAIL load_end: busy=%h ready=%b want 0/0", busy, ld_if.ld_ready);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_collision();
    logic [VW-1:0] exp30;
    int beats;
    exp30 = {32'h11, 32'h11, 32'h11, 32'h11, 32'h55};
    ld_if.ld_start = 1; ld_if.ld_vd = 2;
    tick();
    ld_if.ld_start = 0; ra1 = 2;
    ld_if.ld_valid = 1; ld_if.ld_data = 32'h55;
    we = 1; wa = 2; wmask = '1; wd = {NLANES{32'h11}};
    tick();
    ld_if.ld_valid = 0; we = 0;
    model_write(2, '1, {NLANES{32'h11}});
    m[2][0] = 32'h55;
    #1;
    n_checks++; if (rd1 !== exp30) begin n_fail++; $display("FAIL collision: got %h want %h", rd1, exp30); end

    // Finish the load while the write port keeps hitting the busy register
    beats = 1;
    for (int c = 0; c < 20 && beats < NLANES; c++) begin
      ld_if.ld_valid = (c >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
      ld_if.ld_data  = $urandom;
      we    = 1'($urandom_range(0, 1));
      wa    = AW'($urandom_range(0, 3));
      wmask = NLANES'($urandom);
      for (int l = 0; l < NLANES; l++) wd[l*XLEN +: XLEN] = $urandom;
      ra2 = wa;
      tick();
      if (we) model_write(int'(wa), wmask, wd);
      if (ld_if.ld_valid) begin
        m[2][beats] = ld_if.ld_data;
        beats++;
      end
      ld_if.ld_valid = 0; we = 0;
      #1;
      n_checks++; if (rd1 !== mvec(2)) begin n_fail++; $display("FAIL busy_write_rd1: got %h want %h", rd1, mvec(2)); end
      n_checks++; if (rd2 !== mvec(int'(ra2))) begin n_fail++; $display("FAIL busy_write_rd2 ra=%0d: got %h want %h", ra2, rd2, mvec(int'(ra2))); end
    end
    n_checks++; if (beats != NLANES) begin n_fail++; $display("FAIL collision_beats: got %0d want %0d", beats, NLANES); end
    n_checks++; if (ld_if.ld_done !== 1'b1) begin n_fail++; $display("FAIL collision_done: got %b want 1", ld_if.ld_done); end
    tick();
    n_checks++; if (busy !== '0) begin n_fail++; $display("FAIL collision_busy_end: got %h want 0", busy); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_load();
    logic [NREGS-1:0] b4;
    b4 = NREGS'(1) << 4;
    ra1 = 4;
    ld_if.ld_start = 1; ld_if.ld_vd = 4;
    tick();
    ld_if.ld_start = 0;
    for (int k = 0; k < 3; k++) begin
      ld_if.ld_valid = 1; ld_if.ld_data = $urandom;
      tick();
      m[4][k] = ld_if.ld_data;
      ld_if.ld_valid = 0;
    end
    n_checks++; if (rd1 !== mvec(4)) begin n_fail++; $display("FAIL partial_load: got %h want %h", rd1, mvec(4)); end
    #2 reset = 1'b0;
    #1;
    model_clear();
    n_checks++; if (busy !== '0 || ld_if.ld_ready !== 1'b0 || ld_if.ld_done !== 1'b0) begin
      n_fail++; $display("FAIL midload_reset_ctrl: busy=%h ready=%b done=%b want 0/0/0", busy, ld_if.ld_ready, ld_if.ld_done);
    end
    for (int r = 0; r < NREGS; r++) begin
      ra1 = AW'(r);
      #1;
      n_checks++; if (rd1 !== '0) begin n_fail++; $display("FAIL midload_reset_clear r=%0d: got %h want 0", r, rd1); end
    end
    repeat (2) tick();
    #2 reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (ld_if.ld_done !== 1'b0 || ld_if.ld_ready !== 1'b0 || busy !== '0) begin
        n_fail++; $display("FAIL after_reset_idle: done=%b ready=%b busy=%h want 0/0/0", ld_if.ld_done, ld_if.ld_ready, busy);
      end
    end
    ra1 = 4;
    ld_if.ld_start = 1; ld_if.ld_vd = 4;
    tick();
    ld_if.ld_start = 0;
    n_checks++; if (ld_if.ld_ready !== 1'b1 || busy !== b4) begin
      n_fail++; $display("FAIL restart_accept: ready=%b busy=%h want 1/%h", ld_if.ld_ready, busy, b4);
    end
    for (int k = 0; k < NLANES; k++) begin
      ld_if.ld_valid = 1; ld_if.ld_data = $urandom;
      tick();
      m[4][k] = ld_if.ld_data;
      ld_if.ld_valid = 0;
    end
    n_checks++; if (ld_if.ld_done !== 1'b1) begin n_fail++; $display("FAIL restart_done: got %b want 1", ld_if.ld_done); end
    n_checks++; if (rd1 !== mvec(4)) begin n_fail++; $display("FAIL restart_contents: got %h want %h", rd1, mvec(4)); end
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_read_latency();
    logic [XLEN-1:0] exp_now;
    we = 1; wa = 1; wmask = 5'b00001;
    for (int l = 0; l < NLANES; l++) wd[l*XLEN +: XLEN] = $urandom;
    wd[XLEN-1:0] = 32'hDEAD;
    ra1 = 1;
    #1;
`ifdef VRF_BYPASS_EN
    exp_now = 32'hDEAD;
`else
    exp_now = m[1][0];
`endif
    n_checks++; if (rd1[XLEN-1:0] !== exp_now) begin n_fail++; $display("FAIL same_cycle_read: got %h want %h", rd1[XLEN-1:0], exp_now); end
    tick();
    model_write(1, 5'b00001, wd);
    we = 0;
    #1;
    n_checks++; if (rd1[XLEN-1:0] !== 32'hDEAD) begin n_fail++; $display("FAIL next_cycle_read: got %h want 0000dead", rd1[XLEN-1:0]); end
    n_checks++; if (rd1 !== mvec(1)) begin n_fail++; $display("FAIL next_cycle_vec: got %h want %h", rd1, mvec(1)); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_final_sweep();
    for (int r = 0; r < 16; r++) begin
      ra1 = AW'(r);
      ra2 = AW'(15 - r);
      #1;
      n_checks++; if (rd1 !== mvec(r)) begin n_fail++; $display("FAIL sweep_rd1 r=%0d: got %h want %h", r, rd1, mvec(r)); end
      n_checks++; if (rd2 !== mvec(15 - r)) begin n_fail++; $display("FAIL sweep_rd2 r=%0d: got %h want %h", 15 - r, rd2, mvec(15 - r)); end
    end
  endtask

  initial begin
    test_reset();
    test_masked_write();
    test_stream_load();
    test_collision();
    test_reset_mid_load();
    test_read_latency();
    test_final_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
